// File: rtl/fft_frame_ctrl_if.sv
// Frame-controller signal bundle: start handshake, sample-buffer read, FFT strobes, status.
// master = controller side, slave = system/FFT side.
interface fft_frame_ctrl_if #(
  parameter int BEATS        = 32,
  parameter int MAX_INFLIGHT = 2
);
  localparam int AW = $clog2(BEATS);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  logic          start;
  logic          bank_sel;
  logic          start_ready;
  logic          mem_rd_en;
  logic [AW:0]   mem_rd_addr;
  logic          fft_valid_in;
  logic          fft_valid_out;
  logic [AW-1:0] out_beat_idx;
  logic          frame_done;
  logic [IW-1:0] inflight;
  logic          busy;
  logic          clr_err;
  logic          err_unexp;
  logic          err_timeout;

  modport master (
    input  start, bank_sel, fft_valid_out, clr_err,
    output start_ready, mem_rd_en, mem_rd_addr, fft_valid_in, out_beat_idx,
           frame_done, inflight, busy, err_unexp, err_timeout
  );

  modport slave (
    output start, bank_sel, fft_valid_out, clr_err,
    input  start_ready, mem_rd_en, mem_rd_addr, fft_valid_in, out_beat_idx,
           frame_done, inflight, busy, err_unexp, err_timeout
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// FFT frame sequencer: feeds BEATS buffer reads per accepted start, tracks frames in flight, flags errors.
// Reads start the cycle after accept; start is refused (never queued) while start_ready is low.
module fft_frame_ctrl #(
  parameter int BEATS        = 32,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 128
) (
  input  logic             clk,
  input  logic             rst,
  fft_frame_ctrl_if.master bus
);
  localparam int AW = $clog2(BEATS);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST     = AW'(BEATS - 1);
  localparam logic [IW-1:0] MAXF     = IW'(MAX_INFLIGHT);
  localparam logic [WW-1:0] TMO      = WW'(TIMEOUT);
  localparam logic [WW-1:0] TMO_PREV = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, FEED} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] feed_cnt_q, feed_cnt_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          bank_q, bank_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          vin_q, done_q, done_d, busy_q, busy_d;
  logic          unexp_q, unexp_d, tmo_q, tmo_d;
  logic          accept, have_frames, beat_ok, unexp_evt, wd_run, tmo_evt;

  // A frame_done in this cycle frees a slot, so a start can be taken even at the limit.
  assign bus.start_ready = ((state_q == IDLE) || (feed_cnt_q == LAST)) &&
                           ((inflight_q < MAXF) || done_q);
  assign accept = bus.start && bus.start_ready;

  always_comb begin
    state_d    = state_q;
    feed_cnt_d = feed_cnt_q;
    bank_d     = bank_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = FEED;
          feed_cnt_d = '0;
          bank_d     = bus.bank_sel;
        end
      end
      FEED: begin
        if (feed_cnt_q == LAST) begin
          feed_cnt_d = '0;
          if (accept) begin
            bank_d = bus.bank_sel;
          end else begin
            state_d = IDLE;
          end
        end else begin
          feed_cnt_d = feed_cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    have_frames = (inflight_q != '0);
    beat_ok     = bus.fft_valid_out && have_frames;
    unexp_evt   = bus.fft_valid_out && !have_frames;

    out_cnt_d = out_cnt_q;
    if (beat_ok) begin
      out_cnt_d = (out_cnt_q == LAST) ? '0 : out_cnt_q + AW'(1);
    end
    done_d = beat_ok && (out_cnt_q == LAST);

    inflight_d = inflight_q;
    if (accept && !done_q) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!accept && done_q) begin
      inflight_d = inflight_q - IW'(1);
    end

    // Watchdog only runs once feeding has finished; it holds during FEED.
    wd_run  = have_frames && (state_q == IDLE) && !bus.fft_valid_out;
    tmo_evt = wd_run && (wd_q == TMO_PREV);
    wd_d    = wd_q;
    if (!have_frames || bus.fft_valid_out) begin
      wd_d = '0;
    end else if (wd_run && (wd_q != TMO)) begin
      wd_d = wd_q + WW'(1);
    end

    unexp_d = unexp_evt || (unexp_q && !bus.clr_err);
    tmo_d   = tmo_evt || (tmo_q && !bus.clr_err);
    busy_d  = (state_d != IDLE) || (inflight_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      feed_cnt_q <= '0;
      out_cnt_q  <= '0;
      bank_q     <= 1'b0;
      inflight_q <= '0;
      wd_q       <= '0;
      vin_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      unexp_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      feed_cnt_q <= feed_cnt_d;
      out_cnt_q  <= out_cnt_d;
      bank_q     <= bank_d;
      inflight_q <= inflight_d;
      wd_q       <= wd_d;
      vin_q      <= (state_q == FEED);
      done_q     <= done_d;
      busy_q     <= busy_d;
      unexp_q    <= unexp_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.mem_rd_en    = (state_q == FEED);
  assign bus.mem_rd_addr  = {bank_q, feed_cnt_q};
  assign bus.fft_valid_in = vin_q;
  assign bus.out_beat_idx = out_cnt_q;
  assign bus.frame_done   = done_q;
  assign bus.inflight     = inflight_q;
  assign bus.busy         = busy_q;
  assign bus.err_unexp    = unexp_q;
  assign bus.err_timeout  = tmo_q;
endmodule
